// File: rtl/accel_stage_pkg.sv
// Shared state encoding and default widths for the vector accumulate stage.
package accel_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ACC_W  = 48;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

endpackage

// File: rtl/sat_clamp.sv
// Combinational clamp of a wide signed sum into the DATA_W output range.
module sat_clamp #(
  parameter int ACC_W  = 48,
  parameter int DATA_W = 32
) (
  input  logic signed [ACC_W-1:0]  sum,
  output logic signed [DATA_W-1:0] clamped,
  output logic                     sat
);

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Returns {sat_flag, clamped_value}; in-range sums simply drop the upper bits.
  function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] x);
    if (x > MAX_V)
      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    else if (x < MIN_V)
      return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, x[DATA_W-1:0]};
  endfunction

  assign {sat, clamped} = saturate(sum);

endmodule

// File: rtl/accum_stage.sv
// Vector accumulator: sums len words, then presents one saturated, optionally
// rectified result and holds it until the downstream handshake.
module accum_stage #(
  parameter int DATA_W = accel_stage_pkg::DATA_W,
  parameter int ACC_W  = accel_stage_pkg::ACC_W,
  parameter int LEN_W  = accel_stage_pkg::LEN_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     ready_out,
  input  logic [LEN_W-1:0]         len,
  input  logic                     relu_en,
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     sat_out,
  input  logic                     ready_in
);

  import accel_stage_pkg::*;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]          cnt;
  logic [LEN_W-1:0]          len_q;
  logic                      relu_q;

  logic                      accept;
  logic                      last_word;
  logic                      relu_sel;
  logic [LEN_W-1:0]          len_eff;
  logic signed [ACC_W-1:0]   word_ext;
  logic signed [ACC_W-1:0]   sum_nxt;
  logic signed [DATA_W-1:0]  clamped;
  logic signed [DATA_W-1:0]  result;
  logic                      sat;

  function automatic logic signed [DATA_W-1:0] relu(
    input logic signed [DATA_W-1:0] x,
    input logic                     en
  );
    return (en && x < 0) ? '0 : x;
  endfunction

  // Handshake readiness depends on state only, keeping valid_in/data_in off any output path.
  assign ready_out = (state != OUTPUT);
  assign accept    = valid_in && ready_out;
  assign word_ext  = {{(ACC_W-DATA_W){data_in[DATA_W-1]}}, data_in};
  assign len_eff   = (len == '0) ? LEN_W'(1) : len;

  // The first word of a vector uses the live len/relu_en; later words use the latched copies.
  always_comb begin
    sum_nxt   = acc + word_ext;
    last_word = (({1'b0, cnt} + (LEN_W+1)'(1)) == {1'b0, len_q});
    relu_sel  = relu_q;
    if (state == IDLE) begin
      sum_nxt   = word_ext;
      last_word = (len_eff == LEN_W'(1));
      relu_sel  = relu_en;
    end
  end

  sat_clamp #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_sat_clamp (
    .sum     (sum_nxt),
    .clamped (clamped),
    .sat     (sat)
  );

  assign result = relu(clamped, relu_sel);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      relu_q    <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      sat_out   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= sum_nxt;
            if (state == IDLE) begin
              cnt    <= LEN_W'(1);
              len_q  <= len_eff;
              relu_q <= relu_en;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
            if (last_word) begin
              state     <= OUTPUT;
              data_out  <= result;
              sat_out   <= sat;
              valid_out <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        OUTPUT: begin
          if (ready_in) begin
            state     <= IDLE;
            valid_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_stage.sv
// Directed bench for accum_stage: hand-computed vectors checked with immediate assertions.
module tb_accum_stage;

  logic        clk;
  logic        rstn;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready_out;
  logic [7:0]  len;
  logic        relu_en;
  logic        valid_out;
  logic [31:0] data_out;
  logic        sat_out;
  logic        ready_in;

  int tests = 0;
  int fails = 0;

  accum_stage dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .len       (len),
    .relu_en   (relu_en),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sat_out   (sat_out),
    .ready_in  (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the word is presented across exactly one rising edge.
  task automatic feed(input logic [31:0] v);
    valid_in = 1'b1;
    data_in  = v;
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic handshake();
    ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "bench timed out");
  end

  initial begin
    rstn     = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    len      = 8'd0;
    relu_en  = 1'b0;
    ready_in = 1'b0;
    idle(2);
    chk1 ("rst_valid",  valid_out, 1'b0);
    chk32("rst_data",   data_out,  32'h0);
    chk1 ("rst_sat",    sat_out,   1'b0);
    chk1 ("rst_ready",  ready_out, 1'b1);
    rstn = 1'b1;
    idle(1);
    chk1 ("post_rst_ready", ready_out, 1'b1);

    // Single-word vector
    len = 8'd1;
    feed(32'd10);
    chk1 ("len1_valid", valid_out, 1'b1);
    chk32("len1_data",  data_out,  32'd10);
    chk1 ("len1_sat",   sat_out,   1'b0);
    chk1 ("len1_ready", ready_out, 1'b0);
    handshake();
    chk1 ("len1_done_valid", valid_out, 1'b0);
    chk1 ("len1_done_ready", ready_out, 1'b1);

    // Four words with gaps; len changed mid-vector must be ignored
    len = 8'd4;
    feed(32'd1);
    chk1 ("gap_ready1", ready_out, 1'b1);
    idle(2);
    feed(32'd2);
    idle(1);
    chk1 ("gap_ready2", ready_out, 1'b1);
    feed(32'd3);
    chk1 ("gap_valid3", valid_out, 1'b0);
    len = 8'd1;
    feed(32'd4);
    chk1 ("gap_valid",  valid_out, 1'b1);
    chk32("gap_data",   data_out,  32'd10);
    chk1 ("gap_ready",  ready_out, 1'b0);
    handshake();
    chk1 ("gap_done", valid_out, 1'b0);

    // Negative sum, ReLU off then on (relu_en dropped mid-vector)
    len = 8'd2;
    relu_en = 1'b0;
    feed(32'hFFFF_FFFD);
    feed(32'hFFFF_FFFE);
    chk32("neg_data", data_out, 32'hFFFF_FFFB);
    chk1 ("neg_sat",  sat_out,  1'b0);
    handshake();
    relu_en = 1'b1;
    feed(32'hFFFF_FFFD);
    relu_en = 1'b0;
    feed(32'hFFFF_FFFE);
    chk32("relu_data", data_out, 32'h0);
    chk1 ("relu_sat",  sat_out,  1'b0);
    handshake();

    // Saturation both directions, and ReLU after negative saturation
    feed(32'h7FFF_FFFF);
    feed(32'h7FFF_FFFF);
    chk32("satp_data", data_out, 32'h7FFF_FFFF);
    chk1 ("satp_sat",  sat_out,  1'b1);
    handshake();
    feed(32'h8000_0000);
    feed(32'h8000_0000);
    chk32("satn_data", data_out, 32'h8000_0000);
    chk1 ("satn_sat",  sat_out,  1'b1);
    handshake();
    relu_en = 1'b1;
    feed(32'h8000_0000);
    feed(32'h8000_0000);
    chk32("satn_relu_data", data_out, 32'h0);
    chk1 ("satn_relu_sat",  sat_out,  1'b1);
    handshake();
    relu_en = 1'b0;

    // len 0 behaves as len 1
    len = 8'd0;
    feed(32'hFFFF_FFF7);
    chk1 ("len0_valid", valid_out, 1'b1);
    chk32("len0_data",  data_out,  32'hFFFF_FFF7);
    handshake();

    // Downstream stall with a word pending upstream that must not be taken
    len = 8'd1;
    feed(32'd7);
    valid_in = 1'b1;
    data_in  = 32'd100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1 ("stall_valid", valid_out, 1'b1);
      chk32("stall_data",  data_out,  32'd7);
      chk1 ("stall_ready", ready_out, 1'b0);
    end
    handshake();
    valid_in = 1'b0;
    data_in  = '0;
    chk1 ("stall_done_valid", valid_out, 1'b0);
    chk1 ("stall_done_ready", ready_out, 1'b1);
    feed(32'd5);
    chk32("after_stall_data", data_out, 32'd5);
    handshake();

    // Reset mid-vector discards the partial sum
    len = 8'd4;
    feed(32'd1);
    feed(32'd2);
    rstn = 1'b0;
    #1;
    chk1 ("midrst_valid", valid_out, 1'b0);
    chk32("midrst_data",  data_out,  32'h0);
    chk1 ("midrst_ready", ready_out, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    len = 8'd2;
    feed(32'd20);
    chk1 ("midrst_first_valid", valid_out, 1'b0);
    feed(32'd30);
    chk1 ("midrst_new_valid", valid_out, 1'b1);
    chk32("midrst_new_data",  data_out,  32'd50);
    chk1 ("midrst_new_sat",   sat_out,   1'b0);
    handshake();
    chk1 ("final_idle", valid_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accum_stage.md
ACCUM_STAGE -- requirements
Module: accum_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of input/output data words (signed two's complement).
REQ-002 Parameter ACC_W, default 48, internal accumulator width; SHALL be >= DATA_W + LEN_W.
REQ-003 Parameter LEN_W, default 8, width of the vector length input.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 valid_in  input  1  upstream word valid (driven by skid buffer valid_out).
REQ-007 data_in  input  DATA_W  upstream signed word.
REQ-008 ready_out  output  1  this stage accepts a word this cycle.
REQ-009 len  input  LEN_W  words per vector; sampled on first accepted word of a vector.
REQ-010 relu_en  input  1  clamp negative results to 0; sampled with len.
REQ-011 valid_out  output  1  result valid.
REQ-012 data_out  output  DATA_W  saturated (and optionally rectified) vector sum.
REQ-013 sat_out  output  1  result was saturated; qualified by valid_out.
REQ-014 ready_in  input  1  downstream accepts result.

Function
REQ-015 Word accepted iff valid_in && ready_out at a rising edge; result transferred iff valid_out && ready_in.
REQ-016 FSM states IDLE, ACCUM, OUTPUT; ready_out SHALL be 1 in IDLE and ACCUM, 0 in OUTPUT, decoded from state only.
REQ-017 IDLE: on accept, acc <= sext(data_in), cnt <= 1, latch len/relu_en; go ACCUM, or OUTPUT if latched len <= 1.
REQ-018 len == 0 SHALL be treated as len == 1.
REQ-019 ACCUM: on accept, acc <= acc + sext(data_in), cnt <= cnt + 1; when cnt + 1 == latched len go OUTPUT; no accept -> hold.
REQ-020 Entering OUTPUT: data_out/sat_out registered same edge from the final sum; valid_out = 1 one cycle after last word accepted.
REQ-021 Saturation: sum > 2^(DATA_W-1)-1 -> max positive, sat_out=1; sum < -2^(DATA_W-1) -> min negative, sat_out=1; else truncation, sat_out=0.
REQ-022 ReLU applied after saturation; negative result with relu_en -> data_out 0, sat_out unchanged.
REQ-023 OUTPUT: data_out, sat_out, valid_out held stable until ready_in; on handshake go IDLE, valid_out <= 0.
REQ-024 No word accepted in the OUTPUT cycle of the handshake; next vector starts earliest the following cycle.
REQ-025 Changes to len/relu_en mid-vector SHALL have no effect on the current vector.

Reset
REQ-026 rstn low asynchronously forces state IDLE, acc 0, cnt 0, valid_out 0, data_out 0, sat_out 0.
REQ-027 Reset mid-vector or mid-OUTPUT discards the partial vector/result; first word after rstn release starts a new vector.
REQ-028 ready_out SHALL be 1 during and after reset (IDLE decode).

Structure
REQ-029 Package accel_stage_pkg holds state enum (IDLE, ACCUM, OUTPUT) and default width constants DATA_W/ACC_W/LEN_W.
REQ-030 Saturation SHALL be a sub-module sat_clamp (ACC_W in, DATA_W out, sat flag), purely combinational.
REQ-031 No combinational path from valid_in/data_in to any output.

Verification
REQ-032 len=1, relu_en=0, word 10 -> valid_out next cycle, data_out=10, sat_out=0.
REQ-033 len=4, words 1,2,3,4 with gaps in valid_in -> single result 10; ready_out=0 only while valid_out=1.
REQ-034 len=2, words -3,-2: relu_en=0 -> data_out=-5; relu_en=1 -> data_out=0.
REQ-035 len=2, words 0x7FFFFFFF twice -> data_out=0x7FFFFFFF, sat_out=1; 0x80000000 twice -> 0x80000000, sat_out=1.
REQ-036 ready_in low 5 cycles in OUTPUT -> valid_out/data_out stable, ready_out=0; on ready_in=1 returns IDLE next cycle.
REQ-037 rstn pulsed after 2 of 4 words -> outputs 0; next len=2 vector 20,30 -> data_out=50.
